// File: rtl/pam_dac_sched.sv
// PAM symbol scheduler: debounced mode select, one-deep symbol holding register,
// and a DAC8820 parallel-bus write sequencer that fires once per symbol period.
module pam_dac_sched #(
    parameter int SYM_PERIOD = 50,
    parameter int DEB_CYCLES = 50000,
    parameter int SETUP_CYC  = 2,
    parameter int WR_CYC     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [4:0]  datain,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [1:0]  mode,
    output logic        mode_chg,
    output logic        sym_tick,
    output logic        underrun,
    output logic [15:0] dac_data,
    output logic        dac_cs_n,
    output logic        dac_wr_n
);

    localparam int CNT_W = $clog2(SYM_PERIOD);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int PH_W  = $clog2(SETUP_CYC + WR_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } wr_state_e;

    logic             sel_s1_q, sel_s1_d;
    logic             sel_s2_q, sel_s2_d;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             pending_q, pending_d;
    logic [1:0]       mode_q, mode_d;
    logic             mode_chg_q, mode_chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_full_q, hold_full_d;
    logic [4:0]       hold_q, hold_d;
    logic [15:0]      dac_data_q, dac_data_d;
    logic             underrun_q, underrun_d;
    wr_state_e        state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;

    logic             tick;
    logic             xfer;
    logic             launch;
    logic             press;
    logic             mode_upd;
    logic [4:0]       level;

    assign tick     = (cnt_q == CNT_W'(SYM_PERIOD - 1));
    assign xfer     = din_valid & ~hold_full_q;
    assign launch   = tick & hold_full_q;
    assign mode_upd = tick & pending_q;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_s1_d  = sel;
        sel_s2_d  = sel_s1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sel_s2_q != deb_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                deb_d = sel_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        press = deb_q & ~deb_d;

        // A press landing on the clearing tick wins, so it is not lost.
        pending_d = mode_upd ? 1'b0 : pending_q;
        if (press) begin
            pending_d = 1'b1;
        end
        mode_d     = mode_upd ? mode_q + 2'd1 : mode_q;
        mode_chg_d = mode_upd;

        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        if (launch) begin
            hold_full_d = 1'b0;
        end
        if (xfer) begin
            hold_full_d = 1'b1;
            hold_d      = datain;
        end

        // Mapping uses the pre-update mode so a mode change hits the following symbol.
        level = hold_q;
        case (mode_q)
            2'd0:    level = {hold_q[1:0], 3'b000};
            2'd1:    level = {hold_q[2:0], 2'b00};
            2'd2:    level = {hold_q[3:0], 1'b0};
            default: level = hold_q;
        endcase
        dac_data_d = launch ? {level, 11'b0} : dac_data_q;
        underrun_d = tick & ~hold_full_q;
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        case (state_q)
            SETUP: begin
                if (ph_q == PH_W'(SETUP_CYC - 1)) begin
                    state_d = STROBE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            STROBE: begin
                if (ph_q == PH_W'(WR_CYC - 1)) begin
                    state_d = HOLD;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (launch) begin
            state_d = SETUP;
            ph_d    = '0;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_s1_q    <= 1'b1;
            sel_s2_q    <= 1'b1;
            deb_q       <= 1'b1;
            deb_cnt_q   <= '0;
            pending_q   <= 1'b0;
            mode_q      <= 2'd0;
            mode_chg_q  <= 1'b0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            hold_q      <= 5'd0;
            dac_data_q  <= 16'h0000;
            underrun_q  <= 1'b0;
            state_q     <= IDLE;
            ph_q        <= '0;
        end else begin
            sel_s1_q    <= sel_s1_d;
            sel_s2_q    <= sel_s2_d;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            pending_q   <= pending_d;
            mode_q      <= mode_d;
            mode_chg_q  <= mode_chg_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            dac_data_q  <= dac_data_d;
            underrun_q  <= underrun_d;
            state_q     <= state_d;
            ph_q        <= ph_d;
        end
    end

    assign din_ready = ~hold_full_q;
    assign mode      = mode_q;
    assign mode_chg  = mode_chg_q;
    assign sym_tick  = tick;
    assign underrun  = underrun_q;
    assign dac_data  = dac_data_q;
    assign dac_cs_n  = (state_q == IDLE);
    assign dac_wr_n  = (state_q != STROBE);

endmodule
